queue_read_scheduler: RTL and testbench
=======================================

Name: queue_read_scheduler

Overview:
Read-side controller for the four-queue symbol buffer datapath. It generates the 5-slot write phase `count` that the datapath uses. Once per slot it picks at most one non-empty queue to dequeue and drives the one-hot `reading` strobe during phase 4. It also reports the dequeued head symbol and per-queue transmit statistics. The arbitration policy and read pacing are selectable at run time.

Parameters:
NUM_PHASES, 5, slot length in clocks; phase counts 0..NUM_PHASES-1, and the decision/strobe phase is NUM_PHASES-1 (= 4).
CNT_W, 16, width of the sent/idle statistics counters.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
en  in  1  slot enable; sampled only when phase==0
mode  in  2  0=round robin, 1=strict priority (q1>q2>q3>q4), 2=longest-queue-first, 3=hold (no reads)
read_div  in  4  minimum completed slots between grants; 0 = every slot
count1..count4  in  3 each  queue occupancy from datapath, 0..6
head1..head4  in  2 each  head symbol of each queue (buffer bits [11:10])
count  out  3  slot phase to datapath
reading  out  4  one-hot dequeue strobe; bit0=q1, bit1=q2, bit2=q3, bit3=q4
tx_valid  out  1  dequeued symbol valid
tx_data  out  4  {queue id[1:0], symbol[1:0]}
sent1..sent4  out  CNT_W each  grants issued per queue
idle_slots  out  CNT_W  eligible slots with all queues empty

Behaviour:
- Reset (async, rst_n=0): immediately force count=0, reading=0, tx_valid=0, tx_data=0, sent1..4=0, idle_slots=0. Internal rr_ptr=3 (so q1 is searched first) and div_cnt=0.
- Phase counter:
  - At phase 0, if en=0 the counter holds at 0.
  - Otherwise count advances 0→1→2→3→4→0, one step per clock.
  - A started slot always completes, so phase 4 lasts exactly one clock.
- Decision point: the rising edge where count goes 3→4.
  - Occupancy and heads are stable here, because the datapath only updates on phase-4 edges.
  - A slot is eligible when mode!=3 and div_cnt>=read_div.
- Grant selection, candidates are queues with countN!=0:
  - Round robin: search order rr_ptr+1, +2, +3, +4 (mod 4).
  - Strict priority: lowest index wins.
  - Longest-queue-first: largest countN wins; ties resolved in round-robin search order.
  - Any countN value, including an out-of-range 7, is used as is; the only test applied is countN!=0.
- Outputs at the decision edge when a grant is made:
  - reading <= one-hot of the winner.
  - tx_valid <= 1.
  - tx_data <= {winner id, headN}.
  - sentN increments (wraps at 2^CNT_W).
  - rr_ptr <= winner; rr_ptr updates on every grant in every mode.
  - div_cnt <= 0.
- Eligible slot with no candidate: reading=0 and tx_valid=0. idle_slots increments (wraps) and div_cnt is unchanged.
- Ineligible slot (div_cnt<read_div or mode=3): reading=0 and tx_valid=0. idle_slots is unchanged.
- Pacing counter: div_cnt increments, saturating at 15, on each 4→0 edge, except when that slot granted (div_cnt was already cleared).
- Strobe timing:
  - reading and tx_valid are high only while count==4.
  - Both clear on the 4→0 edge.
  - Latency from decision inputs to strobe is 1 clock.
  - The scheduler never strobes an empty queue.
- reading is always 0 or one-hot.
- mode and read_div changes take effect at the next decision edge. rr_ptr is preserved across mode changes.
- Reset asserted during phase 4 drops reading at once. After release the block restarts at phase 0.

Test Plan:
1. Phase ticking: en=1 from reset → count sequence 0,1,2,3,4,0 repeating. en=0 at phase 2 → the slot finishes through 4, then count holds at 0.
2. Round robin: mode=0, read_div=0, counts 2,2,2,2 → reading 1,2,4,8,1 on successive slots; sent1..4 = 2,1,1,1 after 5 slots.
3. Strict priority: mode=1, counts 0,3,1,0 with head2=2'b10 → reading=4'b0010, tx_data=4'b0110, tx_valid high only during phase 4.
4. Longest-queue-first tie: mode=2, counts 5,6,6,1, rr_ptr=1 → q3 wins (reading=4'b0100). Next slot with counts 5,6,5,1 → q2.
5. Pacing and empty: mode=0, read_div=2, all counts=2 → grants in slots 3,6,9 only. All counts 0 with read_div=0 → reading stays 0 and idle_slots increments by 1 per slot.
6. Hold and reset: mode=3 → no strobes and idle_slots frozen. rst_n low mid-phase-4 → reading=0 immediately; sent counters read 0 after release.

Source files
------------

// File: rtl/queue_read_scheduler.sv
// ----------------------------------------------------------------------------
// queue_read_scheduler
//
// Read-side controller for the four-queue symbol buffer. It runs the slot
// phase counter shared with the datapath. In each slot it chooses at most one
// non-empty queue to dequeue and strobes it during the last phase. It also
// reports the dequeued head symbol and keeps per-queue transmit statistics.
//
// Handshake: o_tx_valid is a pure strobe with no back-pressure. When it is
// high, o_tx_data carries the dequeued {queue id, symbol} for that cycle only,
// and o_reading is the matching one-hot dequeue request to the datapath.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), async active-low reset
//   i_en                  slot enable, sampled only while phase == 0
//   i_mode                0 round robin, 1 strict priority, 2 longest first,
//                         3 hold (no reads)
//   i_read_div            minimum completed slots between grants
//   i_count1..4           queue occupancy from the datapath
//   i_head1..4            head symbol of each queue
//   o_count               slot phase (0..NUM_PHASES-1) to the datapath
//   o_reading             one-hot dequeue strobe, bit0 = q1 .. bit3 = q4
//   o_tx_valid, o_tx_data dequeued symbol strobe and {id[1:0], symbol[1:0]}
//   o_sent1..4            grants issued per queue (wrapping)
//   o_idle_slots          eligible slots that found every queue empty
// ----------------------------------------------------------------------------
module queue_read_scheduler #(
    parameter int NUM_PHASES = 5,
    parameter int CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic [3:0]       i_read_div,
    input  logic [2:0]       i_count1,
    input  logic [2:0]       i_count2,
    input  logic [2:0]       i_count3,
    input  logic [2:0]       i_count4,
    input  logic [1:0]       i_head1,
    input  logic [1:0]       i_head2,
    input  logic [1:0]       i_head3,
    input  logic [1:0]       i_head4,
    output logic [2:0]       o_count,
    output logic [3:0]       o_reading,
    output logic             o_tx_valid,
    output logic [3:0]       o_tx_data,
    output logic [CNT_W-1:0] o_sent1,
    output logic [CNT_W-1:0] o_sent2,
    output logic [CNT_W-1:0] o_sent3,
    output logic [CNT_W-1:0] o_sent4,
    output logic [CNT_W-1:0] o_idle_slots
);

    localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES - 1);
    // The decision is taken on the edge that enters the last phase.
    localparam logic [2:0] DEC_PHASE  = 3'(NUM_PHASES - 2);

    localparam logic [1:0] MODE_RR   = 2'd0;
    localparam logic [1:0] MODE_PRIO = 2'd1;
    localparam logic [1:0] MODE_LQF  = 2'd2;
    localparam logic [1:0] MODE_HOLD = 2'd3;

    logic [2:0]       r_count;
    logic [3:0]       r_reading;
    logic             r_tx_valid;
    logic [3:0]       r_tx_data;
    logic [CNT_W-1:0] r_sent [4];
    logic [CNT_W-1:0] r_idle_slots;
    logic [1:0]       r_rr_ptr;
    logic [3:0]       r_div_cnt;

    logic [2:0]       w_occ  [4];
    logic [1:0]       w_head [4];
    logic [2:0]       w_count_nxt;
    logic             w_found;
    logic [1:0]       w_win;
    logic [2:0]       w_best;
    logic [1:0]       w_idx;
    logic             w_eligible;
    logic             w_grant;

    assign w_occ[0]  = i_count1;
    assign w_occ[1]  = i_count2;
    assign w_occ[2]  = i_count3;
    assign w_occ[3]  = i_count4;
    assign w_head[0] = i_head1;
    assign w_head[1] = i_head2;
    assign w_head[2] = i_head3;
    assign w_head[3] = i_head4;

    // Phase counter: a slot may only start from phase 0 with i_en high, and
    // a started slot always runs to completion.
    always_comb begin
        w_count_nxt = r_count;
        if (r_count == LAST_PHASE) begin
            w_count_nxt = 3'd0;
        end else if (r_count != 3'd0 || i_en) begin
            w_count_nxt = r_count + 3'd1;
        end
    end

    // Winner selection. Round robin and longest-first both walk the queues
    // starting after r_rr_ptr. Longest-first only replaces the current pick
    // on a strictly larger occupancy, so ties go to the earliest in RR order.
    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        w_best  = 3'd0;
        w_idx   = 2'd0;
        if (i_mode == MODE_PRIO) begin
            for (int k = 3; k >= 0; k--) begin
                if (w_occ[k] != 3'd0) begin
                    w_found = 1'b1;
                    w_win   = 2'(k);
                end
            end
        end else begin
            for (int k = 1; k <= 4; k++) begin
                w_idx = r_rr_ptr + 2'(k);
                if (w_occ[w_idx] != 3'd0 &&
                    (!w_found || (i_mode == MODE_LQF && w_occ[w_idx] > w_best))) begin
                    w_found = 1'b1;
                    w_win   = w_idx;
                    w_best  = w_occ[w_idx];
                end
            end
        end
    end

    assign w_eligible = (i_mode != MODE_HOLD) && (r_div_cnt >= i_read_div);
    assign w_grant    = w_eligible && w_found;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count      <= 3'd0;
            r_reading    <= 4'd0;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= 4'd0;
            for (int q = 0; q < 4; q++) r_sent[q] <= '0;
            r_idle_slots <= '0;
            r_rr_ptr     <= 2'd3;
            r_div_cnt    <= 4'd0;
        end else begin
            r_count <= w_count_nxt;
            if (r_count == DEC_PHASE) begin
                if (w_grant) begin
                    r_reading     <= 4'b0001 << w_win;
                    r_tx_valid    <= 1'b1;
                    r_tx_data     <= {w_win, w_head[w_win]};
                    r_sent[w_win] <= r_sent[w_win] + 1'b1;
                    r_rr_ptr      <= w_win;
                    r_div_cnt     <= 4'd0;
                end else begin
                    r_reading  <= 4'd0;
                    r_tx_valid <= 1'b0;
                    if (w_eligible) r_idle_slots <= r_idle_slots + 1'b1;
                end
            end else if (r_count == LAST_PHASE) begin
                r_reading  <= 4'd0;
                r_tx_valid <= 1'b0;
                // A granting slot already cleared the pacing count.
                if (!r_tx_valid && r_div_cnt != 4'd15) r_div_cnt <= r_div_cnt + 4'd1;
            end
        end
    end

    assign o_count      = r_count;
    assign o_reading    = r_reading;
    assign o_tx_valid   = r_tx_valid;
    assign o_tx_data    = r_tx_data;
    assign o_sent1      = r_sent[0];
    assign o_sent2      = r_sent[1];
    assign o_sent3      = r_sent[2];
    assign o_sent4      = r_sent[3];
    assign o_idle_slots = r_idle_slots;

endmodule

// File: tb/tb_queue_read_scheduler.sv
module tb_queue_read_scheduler;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [3:0]  read_div;
  logic [2:0]  c1, c2, c3, c4;
  logic [1:0]  h1, h2, h3, h4;
  logic [2:0]  o_count;
  logic [3:0]  o_reading;
  logic        o_tx_valid;
  logic [3:0]  o_tx_data;
  logic [15:0] o_sent1, o_sent2, o_sent3, o_sent4, o_idle_slots;

  queue_read_scheduler #(.NUM_PHASES(5), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_read_div(read_div),
    .i_count1(c1), .i_count2(c2), .i_count3(c3), .i_count4(c4),
    .i_head1(h1), .i_head2(h2), .i_head3(h3), .i_head4(h4),
    .o_count(o_count), .o_reading(o_reading), .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data),
    .o_sent1(o_sent1), .o_sent2(o_sent2), .o_sent3(o_sent3), .o_sent4(o_sent4),
    .o_idle_slots(o_idle_slots)
  );

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];   // {reading, tx_data}
  int exp_ph[5] = '{3, 4, 0, 0, 0};
  logic [15:0] idle_base;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] oh_id(input logic [3:0] r);
    case (r)
      4'b0010: oh_id = 2'd1;
      4'b0100: oh_id = 2'd2;
      4'b1000: oh_id = 2'd3;
      default: oh_id = 2'd0;
    endcase
  endfunction

  // monitor: pops on every strobe, otherwise demands a quiet read strobe
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_tx_valid) begin
        check("strobe_phase", {29'd0, o_count}, 32'd4);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got reading=%b tx_data=%b expected no grant at %0t",
                   o_reading, o_tx_data, $time);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          check("grant", {24'd0, o_reading, o_tx_data}, {24'd0, e});
        end
      end else begin
        check("quiet_reading", {28'd0, o_reading}, 32'd0);
      end
    end
  end

  // driver tasks
  task automatic wait_count(input logic [2:0] p);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_count == p) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_count: got phase %0d expected phase %0d within 20 cycles", o_count, p);
  endtask

  // Drives occupancy/heads just before the decision edge and queues the
  // expected grant (exp_rd == 0 means no grant). Returns at phase 0.
  task automatic run_slot(input logic [2:0] a1, input logic [2:0] a2, input logic [2:0] a3,
                          input logic [2:0] a4, input logic [3:0] exp_rd);
    logic [1:0] id;
    logic [1:0] hs [4];
    wait_count(3'd3);
    c1 = a1; c2 = a2; c3 = a3; c4 = a4;
    hs[0] = h1; hs[1] = h2; hs[2] = h3; hs[3] = h4;
    if (exp_rd != 4'd0) begin
      id = oh_id(exp_rd);
      exp_q.push_back({exp_rd, id, hs[id]});
    end
    @(negedge clk);
    @(negedge clk);
    check("slot_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 2'd0; read_div = 4'd0;
    c1 = 0; c2 = 0; c3 = 0; c4 = 0;
    h1 = 2'b00; h2 = 2'b01; h3 = 2'b10; h4 = 2'b11;
    #22;
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_count", {29'd0, o_count}, 0);
    check("rst_reading", {28'd0, o_reading}, 0);
    check("rst_tx_valid", {31'd0, o_tx_valid}, 0);
    check("rst_tx_data", {28'd0, o_tx_data}, 0);
    check("rst_sent1", {16'd0, o_sent1}, 0);
    check("rst_idle", {16'd0, o_idle_slots}, 0);

    // 1. phase ticking and en hold
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("phase_seq", {29'd0, o_count}, i % 5);
    end
    wait_count(3'd2);
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("phase_hold", {29'd0, o_count}, exp_ph[i]);
    end
    en = 1'b1;
    @(negedge clk);
    check("phase_restart", {29'd0, o_count}, 1);

    // 2. round robin
    mode = 2'd0; read_div = 4'd0;
    run_slot(2, 2, 2, 2, 4'b0001);
    run_slot(2, 2, 2, 2, 4'b0010);
    run_slot(2, 2, 2, 2, 4'b0100);
    run_slot(2, 2, 2, 2, 4'b1000);
    run_slot(2, 2, 2, 2, 4'b0001);
    check("rr_sent1", {16'd0, o_sent1}, 2);
    check("rr_sent2", {16'd0, o_sent2}, 1);
    check("rr_sent3", {16'd0, o_sent3}, 1);
    check("rr_sent4", {16'd0, o_sent4}, 1);

    // 3. strict priority, head2 = 2'b10 -> tx_data 4'b0110
    mode = 2'd1; h2 = 2'b10;
    run_slot(0, 3, 1, 0, 4'b0010);

    // 4. longest-queue-first, rr_ptr = 1 (q2)
    mode = 2'd2;
    run_slot(5, 6, 6, 1, 4'b0100);
    run_slot(5, 6, 5, 1, 4'b0010);
    run_slot(3, 7, 0, 0, 4'b0010);   // out-of-range 7 is just a larger count

    // 5. pacing, then all-empty idle counting
    mode = 2'd0; read_div = 4'd2;
    idle_base = o_idle_slots;
    run_slot(2, 2, 2, 2, 4'b0000);
    run_slot(2, 2, 2, 2, 4'b0000);
    run_slot(2, 2, 2, 2, 4'b0100);
    run_slot(2, 2, 2, 2, 4'b0000);
    run_slot(2, 2, 2, 2, 4'b0000);
    run_slot(2, 2, 2, 2, 4'b1000);
    run_slot(2, 2, 2, 2, 4'b0000);
    run_slot(2, 2, 2, 2, 4'b0000);
    run_slot(2, 2, 2, 2, 4'b0001);
    check("pace_idle_frozen", {16'd0, o_idle_slots}, {16'd0, idle_base});
    read_div = 4'd0;
    idle_base = o_idle_slots;
    for (int i = 0; i < 4; i++) run_slot(0, 0, 0, 0, 4'b0000);
    check("empty_idle_delta", {16'd0, o_idle_slots - idle_base}, 4);

    // 6. hold mode, then reset during phase 4
    mode = 2'd3;
    idle_base = o_idle_slots;
    for (int i = 0; i < 3; i++) run_slot(2, 2, 2, 2, 4'b0000);
    check("hold_idle_frozen", {16'd0, o_idle_slots}, {16'd0, idle_base});

    mode = 2'd0;
    wait_count(3'd3);
    c1 = 2; c2 = 2; c3 = 2; c4 = 2;
    exp_q.push_back({4'b0010, 2'd1, h2});
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_reading", {28'd0, o_reading}, 0);
    check("rst_mid_valid", {31'd0, o_tx_valid}, 0);
    check("rst_mid_count", {29'd0, o_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("rel_sent1", {16'd0, o_sent1}, 0);
    check("rel_sent2", {16'd0, o_sent2}, 0);
    check("rel_sent3", {16'd0, o_sent3}, 0);
    check("rel_sent4", {16'd0, o_sent4}, 0);
    check("rel_idle", {16'd0, o_idle_slots}, 0);
    check("rel_count", {29'd0, o_count}, 0);
    run_slot(2, 2, 2, 2, 4'b0001);   // rr_ptr back to 3, q1 first
    check("post_rst_sent1", {16'd0, o_sent1}, 1);

    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
